// File: rtl/raster_cmd_decoder.sv
// Serial opcode/parameter beat decoder for the rasterizer front end.
// Assembles PIXEL/LINE/RECT/CLEAR bundles and issues them over a valid/ready port.
module raster_cmd_decoder #(
    parameter int COORD_W = 3,
    parameter int PARAM_W = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_cmd,
    input  logic [PARAM_W-1:0] in_param,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_op,
    output logic [COORD_W-1:0] out_x1,
    output logic [COORD_W-1:0] out_y1,
    output logic [COORD_W-1:0] out_x2,
    output logic [COORD_W-1:0] out_y2,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_PIXEL = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_PIXEL  = 2'd1;
    localparam logic [1:0] ERR_PROTO = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;

    localparam int TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

    // Debug encoding on dbg_state: IDLE=0, LOAD=1, ISSUE=2.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [1:0]         cnt, cnt_n;
    logic [TW-1:0]      tmo, tmo_n;
    logic [1:0]         op_q, op_n;
    logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q;
    logic [COORD_W-1:0] x1_n, y1_n, x2_n, y2_n;
    logic               err_q, err_n;
    logic [1:0]         code_q, code_n;

    logic               accept;
    logic               last_beat;
    logic [COORD_W-1:0] field;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Input side: the source holds in_cmd/in_param stable while in_valid is
    // high and not yet accepted. Output side: the bundle is held stable from
    // out_valid rising until the edge where out_ready is also high.
    assign in_ready  = (state != S_ISSUE) && !rst;
    assign accept    = in_valid && in_ready;
    assign field     = in_param[COORD_W-1:0];
    assign last_beat = (op_q == OP_PIXEL) ? (cnt == 2'd1) : (cnt == 2'd3);

    assign out_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign out_op    = op_q;
    assign out_x1    = x1_q;
    assign out_y1    = y1_q;
    assign out_x2    = x2_q;
    assign out_y2    = y2_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tmo_n   = tmo;
        op_n    = op_q;
        x1_n    = x1_q;
        y1_n    = y1_q;
        x2_n    = x2_q;
        y2_n    = y2_q;
        err_n   = 1'b0;
        code_n  = code_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_cmd == CMD_PIXEL && (&in_param)) begin
                        op_n    = OP_CLEAR;
                        state_n = S_ISSUE;
                    end else if (in_cmd != CMD_NOP) begin
                        op_n    = in_cmd;
                        x1_n    = field;
                        cnt_n   = 2'd1;
                        tmo_n   = '0;
                        state_n = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    if (in_cmd != CMD_NOP) begin
                        // The offending opcode is swallowed, not restarted.
                        err_n   = 1'b1;
                        code_n  = ERR_PROTO;
                        state_n = S_IDLE;
                    end else begin
                        case (cnt)
                            2'd1:    y1_n = field;
                            2'd2:    x2_n = field;
                            default: y2_n = field;
                        endcase
                        cnt_n = cnt + 2'd1;
                        tmo_n = '0;
                        if (last_beat) begin
                            state_n = S_ISSUE;
                        end
                    end
                end else if (TIMEOUT > 0) begin
                    if (tmo == TMO_LAST) begin
                        err_n   = 1'b1;
                        code_n  = ERR_TMO;
                        state_n = S_IDLE;
                    end else begin
                        tmo_n = tmo + TW'(1);
                    end
                end
            end

            S_ISSUE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            tmo    <= '0;
            op_q   <= 2'd0;
            x1_q   <= '0;
            y1_q   <= '0;
            x2_q   <= '0;
            y2_q   <= '0;
            err_q  <= 1'b0;
            code_q <= 2'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tmo    <= tmo_n;
            op_q   <= op_n;
            x1_q   <= x1_n;
            y1_q   <= y1_n;
            x2_q   <= x2_n;
            y2_q   <= y2_n;
            err_q  <= err_n;
            code_q <= code_n;
        end
    end

endmodule
